// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue_if
//  Description : Fetch/decode handshake bundle for the IF/ID instruction
//                queue. The master side is the fetch and decode environment.
//                The slave side is the queue itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_id_queue_if #(
    parameter int DEPTH = 2
) ();
    // Fetch side
    logic [31:0]                  InstrF;
    logic [31:0]                  PCF;
    logic [31:0]                  PCPlus4F;
    logic                         ValidF;
    logic                         ReadyF;
    // Decode side
    logic                         StallD;
    logic                         FlushD;
    logic [31:0]                  InstrD;
    logic [31:0]                  PCD;
    logic [31:0]                  PCPlus4D;
    logic                         ValidD;
    logic [$clog2(DEPTH+1)-1:0]   Count;

    // Environment: drives fetch data and decode control, observes the queue
    modport master (
        output InstrF, PCF, PCPlus4F, ValidF, StallD, FlushD,
        input  ReadyF, InstrD, PCD, PCPlus4D, ValidD, Count
    );

    // Queue: consumes fetch data and decode control, presents the head entry
    modport slave (
        input  InstrF, PCF, PCPlus4F, ValidF, StallD, FlushD,
        output ReadyF, InstrD, PCD, PCPlus4D, ValidD, Count
    );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : Circular FIFO between instruction fetch and decode. Each
//                entry holds {Instr, PC, PCPlus4}. The head is presented
//                first-word fall-through. A NOP with zero PCs is presented
//                when the queue is empty. FlushD discards everything.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  wire logic         clk,
    input  wire logic         rst,      // asynchronous, active low
    if_id_queue_if.slave      bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // Storage needs no reset: Count alone decides which entries are live.
    logic [31:0]        r_instr [DEPTH];
    logic [31:0]        r_pc    [DEPTH];
    logic [31:0]        r_pc4   [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_ready;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;

    // ReadyF depends on Count only, so a full queue never accepts on a
    // same-cycle pop. This keeps the fetch stall path short.
    assign w_ready = (r_count != c_FULL);
    assign w_valid = (r_count != '0);
    assign w_push  = bus.ValidF && w_ready && !bus.FlushD;
    assign w_pop   = w_valid && !bus.StallD && !bus.FlushD;

    assign bus.ReadyF = w_ready;
    assign bus.ValidD = w_valid;
    assign bus.Count  = r_count;

    // Write the pushed instruction into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= bus.InstrF;
            r_pc[r_wr_ptr]    <= bus.PCF;
            r_pc4[r_wr_ptr]   <= bus.PCPlus4F;
        end
    end

    // Pointer and occupancy bookkeeping; a flush returns to the reset state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.FlushD) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Present the head entry, or a NOP bubble when the queue is empty
    always_comb begin
        bus.InstrD   = NOP;
        bus.PCD      = '0;
        bus.PCPlus4D = '0;
        if (w_valid) begin
            bus.InstrD   = r_instr[r_rd_ptr];
            bus.PCD      = r_pc[r_rd_ptr];
            bus.PCPlus4D = r_pc4[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entry count (power of two, 2..8).
REQ-002 SHALL have parameter NOP, default 32'h00000013, meaning instruction presented when empty (addi x0,x0,0).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have InstrF  input  32  instruction word from instruction memory.
REQ-006 SHALL have PCF  input  32  fetch PC of InstrF.
REQ-007 SHALL have PCPlus4F  input  32  PCF+4 from fetch.
REQ-008 SHALL have ValidF  input  1  fetch presents a valid instruction this cycle.
REQ-009 SHALL have ReadyF  output  1  queue can accept; fetch drives StallF = ~ReadyF.
REQ-010 SHALL have StallD  input  1  decode not consuming this cycle.
REQ-011 SHALL have FlushD  input  1  redirect (PCSrcE); discard all queued instructions.
REQ-012 SHALL have InstrD  output  32  head instruction to decode.
REQ-013 SHALL have PCD  output  32  PC of head entry.
REQ-014 SHALL have PCPlus4D  output  32  PC+4 of head entry.
REQ-015 SHALL have ValidD  output  1  head entry valid.
REQ-016 SHALL have Count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 SHALL be a circular FIFO of DEPTH entries, each {Instr, PC, PCPlus4}, read/write pointers $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-018 SHALL push when ValidF && ReadyF && !FlushD: write entry at wr_ptr, wr_ptr+1.
REQ-019 SHALL pop when ValidD && !StallD && !FlushD: rd_ptr+1.
REQ-020 SHALL drive ReadyF = (Count != DEPTH), combinational from Count only (no pop-through when full).
REQ-021 SHALL drive ValidD = (Count != 0).
REQ-022 SHALL present head (first-word fall-through): InstrD/PCD/PCPlus4D = entry[rd_ptr] when ValidD, else InstrD=NOP, PCD=0, PCPlus4D=0.
REQ-023 SHALL give 1-cycle latency: instruction pushed at edge N is on InstrD after edge N when queue was empty.
REQ-024 SHALL, on simultaneous push and pop, keep Count unchanged and advance both pointers.
REQ-025 SHALL, when empty, ignore pop (StallD irrelevant); Count never underflows.
REQ-026 SHALL, when full, ignore ValidF (ReadyF=0); Count never exceeds DEPTH.
REQ-027 SHALL, on FlushD=1 at an edge, set Count=0, rd_ptr=wr_ptr=0, discard any same-cycle push and pop; FlushD overrides StallD.
REQ-028 SHALL preserve FIFO order: instructions leave in push order.
REQ-029 SHALL hold outputs stable while StallD=1 and no flush.

Reset
REQ-030 SHALL, while rst=0, asynchronously force Count=0, pointers=0, ValidD=0, ReadyF=1, InstrD=NOP, PCD=0, PCPlus4D=0; storage array need not be cleared.
REQ-031 SHALL, on rst asserted mid-operation, drop all queued entries immediately; first push after rst=1 appears as head.

Verification
REQ-032 Reset: rst=0 with queue full -> ValidD=0, InstrD=32'h00000013, Count=0, ReadyF=1 before next clk edge.
REQ-033 Stream: push PC 0,4,8 (InstrF A,B,C), StallD=0 -> InstrD A,B,C one per cycle, PCPlus4D 4,8,12, Count stays 1.
REQ-034 Fill: StallD=1, push PC 0,4,8 -> Count=2, ReadyF=0 after 2 pushes, PC 8 not accepted; release StallD -> PCD 0 then 4.
REQ-035 Flush: Count=2, FlushD=1 with ValidF=1 (PC 40) -> next cycle Count=0, ValidD=0, InstrD=NOP; next push PC 40 becomes head.
REQ-036 Simultaneous: Count=1, push PC 92 and pop -> Count=1, PCD=92.
REQ-037 Wrap: 5 push/pop cycles with DEPTH=2 -> pointers wrap, order preserved, no lost or duplicated PC.
